// File: rtl/controle_escalar.sv
// Scalar x 5x5 matrix sequencer: LANES products per beat, 25/LANES beats, done one cycle after the last beat.
// Latency: accept + 25/LANES edges; start is ignored (not queued) while busy. Build option: SATURATE_EN.
// Backpressure: none; the result holds until the next accept.
module controle_escalar #(
    parameter int LANES  = 5,
    parameter int ELEM_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [ELEM_W-1:0]   data_escalar,
    input  logic [25*ELEM_W-1:0] matriz_a,
    output logic                busy,
    output logic                done,
    output logic [25*ELEM_W-1:0] matriz_resultante,
    output logic                overflow
);
    localparam int N = 25;
    localparam logic [4:0] LAST_IDX = 5'(N - LANES);
    localparam logic [4:0] STEP     = 5'(LANES);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;

    logic [ELEM_W-1:0]   escalar_q;
    logic [N*ELEM_W-1:0] matriz_q;
    logic [4:0]          index;
    logic                accept;
    logic                last_beat;

    logic [LANES-1:0][4:0]          lane_idx;
    logic [LANES-1:0][2*ELEM_W-1:0] lane_prod;
    logic [LANES-1:0][ELEM_W-1:0]   lane_res;
    logic [LANES-1:0]               lane_ovf;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_beat  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (index == LAST_IDX) begin
                    last_beat  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shared multiplier bank: lane l always handles element index+l of the current beat.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l]  = index + 5'(l);
            lane_prod[l] = {{ELEM_W{1'b0}}, matriz_q[lane_idx[l]*ELEM_W +: ELEM_W]}
                         * {{ELEM_W{1'b0}}, escalar_q};
            lane_ovf[l]  = |lane_prod[l][2*ELEM_W-1:ELEM_W];
`ifdef SATURATE_EN
            lane_res[l]  = lane_ovf[l] ? {ELEM_W{1'b1}} : lane_prod[l][ELEM_W-1:0];
`else
            lane_res[l]  = lane_prod[l][ELEM_W-1:0];
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            index             <= '0;
            done              <= 1'b0;
            overflow          <= 1'b0;
            matriz_resultante <= '0;
            escalar_q         <= '0;
            matriz_q          <= '0;
        end else begin
            done <= last_beat;
            if (accept) begin
                escalar_q         <= data_escalar;
                matriz_q          <= matriz_a;
                matriz_resultante <= '0;
                overflow          <= 1'b0;
                index             <= '0;
            end else if (state == RUN) begin
                for (int l = 0; l < LANES; l++) begin
                    matriz_resultante[lane_idx[l]*ELEM_W +: ELEM_W] <= lane_res[l];
                end
                overflow <= overflow | (|lane_ovf);
                // Park index at 0 after the last beat so idle lane selects stay in range.
                index    <= last_beat ? 5'd0 : index + STEP;
            end
        end
    end

    assign busy = (state == RUN);

endmodule
